// File: rtl/ahfp_pkg.sv
// ahfp_pkg: shared state encoding and constants for the function sequencer.
package ahfp_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
    localparam logic [31:0] FLOAT_ZERO = 32'h0000_0000;
    localparam int DEF_FUNC_LATENCY = 54;
endpackage

// File: rtl/ahfp_sync_fifo.sv
// ahfp_sync_fifo: synchronous FIFO, pointers carry an extra wrap bit for full/empty.
module ahfp_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop = pop && !empty;
    // a same-edge pop frees the slot, so a push at full is still taken
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/ahfp_func_seq.sv
// ahfp_func_seq: feeds a fixed-latency function pipeline from an input FIFO
// and tags its results with valid/last using a shift register.
module ahfp_func_seq
    import ahfp_pkg::*;
#(
    parameter int FUNC_LATENCY = DEF_FUNC_LATENCY,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] n_items,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] func_dataa,
    input  logic [31:0] func_result,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic        busy,
    output logic        done
);
    state_t state, state_nx;
    logic [15:0] n_lat, accepted, emitted;
    logic [FUNC_LATENCY-1:0] vsr;
    logic dataa_vld, push, pop, full, empty;
    logic [31:0] fifo_dout;

    ahfp_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset_n(reset_n), .push(push), .din(in_data), .pop(pop),
        .dout(fifo_dout), .full(full), .empty(empty)
    );

    assign in_ready = (state == RUN) && !full && (accepted < n_lat);
    assign push = in_valid && in_ready;
    assign pop = (state == RUN) && !empty;
    assign out_valid = vsr[FUNC_LATENCY-1];
    assign out_data = func_result;
    assign out_last = out_valid && (emitted == n_lat - 16'd1);
    assign busy = (state == RUN) || (state == DRAIN);
    assign done = state == FIN;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (n_items == 16'd0) ? FIN : RUN;
            RUN:     if (accepted == n_lat && empty) state_nx = DRAIN;
            DRAIN:   if (out_last) state_nx = FIN;
            default: state_nx = IDLE;
        endcase
    end

    // vsr tracks func_dataa occupancy, so its MSB lines up with func_result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            n_lat <= '0;
            accepted <= '0;
            emitted <= '0;
            vsr <= '0;
            dataa_vld <= 1'b0;
            func_dataa <= FLOAT_ZERO;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                n_lat <= n_items;
                accepted <= '0;
                emitted <= '0;
            end else begin
                if (push) accepted <= accepted + 16'd1;
                if (out_valid) emitted <= emitted + 16'd1;
            end
            func_dataa <= pop ? fifo_dout : FLOAT_ZERO;
            dataa_vld <= pop;
            vsr <= {vsr[FUNC_LATENCY-2:0], dataa_vld};
        end
    end
endmodule

// File: tb/tb_ahfp_func_seq.sv
// tb_ahfp_func_seq: scoreboard bench for ahfp_func_seq with a modelled function pipeline.
module tb_ahfp_func_seq;
    localparam int LAT = 54;
    localparam logic [31:0] SIGN = 32'h8000_0000;

    logic clk = 1'b0;
    logic reset_n, start, in_valid, in_ready, out_valid, out_last, busy, done;
    logic [15:0] n_items;
    logic [31:0] in_data, func_dataa, func_result, out_data;
    logic [31:0] pipe [LAT];

    typedef struct {logic [31:0] d; int c;} exp_t;
    exp_t q[$];
    int tests = 0, fails = 0, cyc = 0;
    int exp_n = 0, beats = 0, done_cnt = 0, done_cyc = -1, last_cyc = -100;

    ahfp_func_seq #(.FUNC_LATENCY(LAT), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .n_items(n_items),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .func_dataa(func_dataa), .func_result(func_result), .out_data(out_data),
        .out_valid(out_valid), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // function model: negate, LAT cycles after func_dataa updates
    always @(posedge clk) begin
        pipe[0] <= func_dataa ^ SIGN;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign func_result = pipe[LAT-1];

    always @(negedge clk) begin
        if (reset_n) begin
            if (in_valid && in_ready) q.push_back('{in_data ^ SIGN, cyc + 2 + LAT});
            if (out_valid) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_out_valid cyc=%0d data=%h required none", cyc, out_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (out_data !== e.d) begin
                        fails++;
                        $display("FAIL out_data got=%h exp=%h", out_data, e.d);
                    end
                    tests++;
                    if (cyc !== e.c) begin
                        fails++;
                        $display("FAIL out_timing got_cyc=%0d exp_cyc=%0d", cyc, e.c);
                    end
                    tests++;
                    if (out_last !== (beats == exp_n - 1)) begin
                        fails++;
                        $display("FAIL out_last beat=%0d got=%b exp=%b", beats, out_last, beats == exp_n - 1);
                    end
                end
                beats++;
                if (out_last) last_cyc = cyc;
            end else if (out_last !== 1'b0) begin
                tests++;
                fails++;
                $display("FAIL out_last_without_valid got=%b exp=0", out_last);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        tests++;
        if ({in_ready, out_valid, out_last, busy, done} !== 5'b0 || func_dataa !== 32'h0) begin
            fails++;
            $display("FAIL %s got rdy/ov/ol/busy/done=%b dataa=%h exp 00000/00000000", tag,
                     {in_ready, out_valid, out_last, busy, done}, func_dataa);
        end
    endtask

    task automatic run_job(input int n, input bit rnd, input int restart_at, output int stalls);
        logic [31:0] fl [4];
        int sent, guard, d0;
        bit fire;
        fl = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        d0 = done_cnt;
        exp_n = n;
        beats = 0;
        stalls = 0;
        @(posedge clk); #1;
        start = 1'b1;
        n_items = n[15:0];
        @(posedge clk); #1;
        start = 1'b0;
        sent = 0;
        guard = 0;
        while (sent < n && guard < 2000) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data = sent < 4 ? fl[sent] : $urandom;
            start = sent == restart_at;
            if (start) n_items = 16'd3;
            @(negedge clk);
            fire = in_valid && in_ready;
            if (in_valid && !fire) stalls++;
            @(posedge clk); #1;
            if (fire) sent++;
            guard++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        tests++;
        if (sent != n) begin
            fails++;
            $display("FAIL feed_timeout sent=%0d exp=%0d", sent, n);
        end
        guard = 0;
        while (done_cnt == d0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        tests++;
        if (done_cnt != d0 + 1) begin
            fails++;
            $display("FAIL done_count got=%0d exp=%0d", done_cnt - d0, 1);
        end
        tests++;
        if (beats != n) begin
            fails++;
            $display("FAIL beat_count got=%0d exp=%0d", beats, n);
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", q.size());
        end
        tests++;
        if (done_cyc != last_cyc + 1) begin
            fails++;
            $display("FAIL done_timing got_cyc=%0d exp_cyc=%0d", done_cyc, last_cyc + 1);
        end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL post_job_idle busy=%b done=%b exp 0/0", busy, done);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_during");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_after");
    endtask

    task automatic test_basic();
        int st;
        run_job(4, 1'b0, -1, st);
    endtask

    task automatic test_zero();
        int d0, hi;
        d0 = done_cnt;
        hi = 0;
        @(posedge clk); #1;
        start = 1'b1;
        n_items = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (in_ready || out_valid || busy) hi++;
        end
        tests++;
        if (done_cnt != d0 + 1) begin
            fails++;
            $display("FAIL zero_done_count got=%0d exp=1", done_cnt - d0);
        end
        tests++;
        if (hi != 0) begin
            fails++;
            $display("FAIL zero_outputs_high got=%0d exp=0", hi);
        end
    endtask

    task automatic test_random();
        int st;
        run_job(20, 1'b1, -1, st);
    endtask

    task automatic test_back_to_back();
        int st;
        run_job(16, 1'b0, -1, st);
        tests++;
        if (st != 0) begin
            fails++;
            $display("FAIL full_rate_stalls got=%0d exp=0", st);
        end
    endtask

    task automatic test_reset_mid();
        int ov;
        @(posedge clk); #1;
        start = 1'b1;
        n_items = 16'd8;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        repeat (9) begin
            in_data = $urandom;
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check_idle_outputs("reset_mid_async");
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        ov = 0;
        repeat (60) begin
            @(negedge clk);
            if (out_valid) ov++;
        end
        tests++;
        if (ov != 0) begin
            fails++;
            $display("FAIL reset_mid_out_valid got=%0d exp=0", ov);
        end
        run_job(5, 1'b0, -1, ov);
    endtask

    task automatic test_restart_ignored();
        int st;
        run_job(6, 1'b1, 2, st);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        n_items = 16'd0;
        in_data = 32'h0;
        test_reset();
        test_basic();
        test_zero();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_restart_ignored();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
